// File: rtl/mult_arbiter.sv
// Round-robin arbiter feeding a shared two-stage signed multiplier.
// Requests are granted only when S1 can accept; results leave in grant order.
module mult_arbiter #(
    parameter int NREQ = 4,
    parameter int NA   = 8,
    parameter int NB   = 8,
    parameter int NX   = NA + NB,
    parameter int NID  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*NA-1:0]   req_a,
    input  logic [NREQ*NB-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    output logic [NID-1:0]       res_id,
    output logic [NX-1:0]        res_x,
    input  logic                 res_ready
);

    logic [NID-1:0] ptr_q, ptr_d;
    logic           v1_q, v1_d;
    logic [NA-1:0]  a1_q, a1_d;
    logic [NB-1:0]  b1_q, b1_d;
    logic [NID-1:0] id1_q, id1_d;
    logic           res_valid_q, res_valid_d;
    logic [NID-1:0] res_id_q, res_id_d;
    logic [NX-1:0]  res_x_q, res_x_d;

    logic           hold2, hold1;
    logic           gnt_found;
    logic [NID-1:0] gnt_id, gnt_next;
    logic [NX-1:0]  prod;

    function automatic int rr_idx(input logic [NID-1:0] p, input int k);
        return (int'(p) + k) % NREQ;
    endfunction

    assign hold2 = res_valid_q & ~res_ready;
    assign hold1 = v1_q & hold2;

    // First valid requester at or after ptr, wrapping; nothing while S1 is stuck.
    always_comb begin
        req_ready = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_next  = '0;
        if (!hold1) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!gnt_found && req_valid[rr_idx(ptr_q, k)]) begin
                    gnt_found                   = 1'b1;
                    gnt_id                      = NID'(rr_idx(ptr_q, k));
                    gnt_next                    = NID'(rr_idx(ptr_q, k + 1));
                    req_ready[rr_idx(ptr_q, k)] = 1'b1;
                end
            end
        end
    end

    // Operands sign-extended to the full product width so the corner -2^(N-1)^2 fits.
    always_comb begin
        prod = $signed({{(NX-NA){a1_q[NA-1]}}, a1_q}) * $signed({{(NX-NB){b1_q[NB-1]}}, b1_q});
    end

    always_comb begin
        ptr_d       = ptr_q;
        v1_d        = v1_q;
        a1_d        = a1_q;
        b1_d        = b1_q;
        id1_d       = id1_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_x_d     = res_x_q;
        if (gnt_found) begin
            ptr_d = gnt_next;
        end
        if (!hold1) begin
            v1_d = gnt_found;
            if (gnt_found) begin
                a1_d  = req_a[int'(gnt_id)*NA +: NA];
                b1_d  = req_b[int'(gnt_id)*NB +: NB];
                id1_d = gnt_id;
            end
        end
        if (!hold2) begin
            res_valid_d = v1_q;
            if (v1_q) begin
                res_x_d  = prod;
                res_id_d = id1_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            v1_q        <= 1'b0;
            a1_q        <= '0;
            b1_q        <= '0;
            id1_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_x_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            id1_q       <= id1_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_x_q     <= res_x_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_x     = res_x_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: per-cycle compare against a two-slot behavioural model
// plus directed scenarios with hand-computed literal expectations.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [15:0] res_x;
    logic        res_ready;

    int total = 0;
    int bad   = 0;

    mult_arbiter #(.NREQ(4), .NA(8), .NB(8), .NX(16), .NID(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .res_valid(res_valid), .res_id(res_id), .res_x(res_x),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one slot per pipeline stage, products by integer arithmetic.
    logic        m1_v, m2_v;
    logic [1:0]  m1_id, m2_id;
    logic [15:0] m1_x, m2_x;
    int          m_ptr;
    logic        h1, h2;
    int          g;
    logic [3:0]  exp_rdy;

    function automatic int rr(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++)
            if (v[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [15:0] mul(input int i);
        int av, bv, x;
        av = $signed(req_a[i*8 +: 8]);
        bv = $signed(req_b[i*8 +: 8]);
        x  = av * bv;
        return x[15:0];
    endfunction

    assign h2 = m2_v & ~res_ready;
    assign h1 = m1_v & h2;

    always_comb begin
        g = h1 ? -1 : rr(req_valid, m_ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_v <= 0; m2_v <= 0; m1_id <= 0; m2_id <= 0;
            m1_x <= 0; m2_x <= 0; m_ptr <= 0;
        end else begin
            if (!h2) begin
                m2_v <= m1_v;
                if (m1_v) begin
                    m2_id <= m1_id;
                    m2_x  <= m1_x;
                end
            end
            if (!h1) begin
                m1_v <= (g >= 0);
                if (g >= 0) begin
                    m1_id <= 2'(g);
                    m1_x  <= mul(g);
                end
            end
            if (g >= 0) m_ptr <= (g + 1) % 4;
        end
    end

    always @(negedge clk) begin
        chk("cmp_ready", 32'(req_ready), 32'(exp_rdy));
        chk("cmp_valid", 32'(res_valid), 32'(m2_v));
        chk("cmp_id",    32'(res_id),    32'(m2_id));
        chk("cmp_x",     32'(res_x),     32'(m2_x));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        res_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic single(input int id, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        req_a = '0;
        req_b = '0;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        req_valid = 4'(1 << id);
        @(negedge clk);
        chk("single_gnt", 32'(req_ready), 32'(1 << id));
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_lat1", 32'(res_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_id", 32'(res_id), 32'(id));
        chk("single_x", 32'(res_x), 32'(exp));
        tick();
    endtask

    logic [15:0] exp_x [4];

    initial begin
        // r3=80*80, r2=7F*81, r1=F0*05, r0=03*FF
        exp_x[0] = 16'hFFFD; exp_x[1] = 16'hFFB0; exp_x[2] = 16'hC0FF; exp_x[3] = 16'h4000;
        rst_n = 1'b0;
        req_valid = 4'b0100;
        req_a = '0;
        req_b = '0;
        res_ready = 1'b1;
        #2;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_x", 32'(res_x), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        rst_n = 1'b1;

        single(0, 8'hFD, 8'h05, 16'hFFF1);
        single(2, 8'h80, 8'h80, 16'h4000);
        single(1, 8'h80, 8'h7F, 16'hC080);
        single(3, 8'h00, 8'h80, 16'h0000);

        // Every requester valid: grants rotate one per cycle.
        do_reset();
        req_a = 32'h807FF003;
        req_b = 32'h808105FF;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rot_gnt", 32'(req_ready), 32'(1 << (k % 4)));
            if (k >= 2) begin
                chk("rot_valid", 32'(res_valid), 32'd1);
                chk("rot_id", 32'(res_id), 32'((k - 2) % 4));
                chk("rot_x", 32'(res_x), 32'(exp_x[(k - 2) % 4]));
            end
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        // Full pipeline, downstream stalled for three cycles.
        do_reset();
        req_valid = 4'b1111;
        tick();
        tick();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_id", 32'(res_id), 32'd0);
            chk("stall_x", 32'(res_x), 32'(exp_x[0]));
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(req_ready), 32'b0100);
        chk("rel_id0", 32'(res_id), 32'd0);
        tick();
        @(negedge clk);
        chk("rel_id1", 32'(res_id), 32'd1);
        chk("rel_x1", 32'(res_x), 32'(exp_x[1]));
        tick();
        @(negedge clk);
        chk("rel_id2", 32'(res_id), 32'd2);
        chk("rel_x2", 32'(res_x), 32'(exp_x[2]));
        req_valid = '0;
        repeat (4) tick();

        // Sparse requesters 1 and 3 starting from ptr=2.
        do_reset();
        single(1, 8'h02, 8'h03, 16'h0006);
        req_a = 32'h807FF003;
        req_b = 32'h808105FF;
        req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("alt_gnt", 32'(req_ready), (k % 2 == 0) ? 32'b1000 : 32'b0010);
            tick();
        end

        // Reset with two results in flight.
        req_valid = 4'b0110;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'b0010);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("post_rst_empty", 32'(res_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("post_rst_valid", 32'(res_valid), 32'd1);
        chk("post_rst_id", 32'(res_id), 32'd1);
        chk("post_rst_x", 32'(res_x), 32'(exp_x[1]));
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
